// File: rtl/singles_merger.sv
// singles_merger
// Merges the 128-bit single-event words from NBLK detector blocks into one
// stream with round-robin arbitration, and inserts a time tag word on every
// counter period boundary. A tag is held back while any block reports that
// its in-flight event straddles the boundary, so the tag always follows
// those events. The output is a single registered valid/ready stage.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   module_id     identifier placed in time tag words
//   period_done   one-cycle pulse at a counter period rollover
//   in_data       block i word at [128*i +: 128]
//   in_valid      per-block valid
//   in_ready      per-block ready (combinational, at most one bit set)
//   in_stall      per-block "event in flight crossed a period boundary"
//   out_data      merged word (registered)
//   out_valid     output valid (registered)
//   out_ready     downstream ready
//   tt_dropped    saturating count of overwritten time tags
//
// Build option: define SINGLES_MERGER_TT_STATS_EN to implement the
// tt_dropped counter; otherwise tt_dropped is tied to 0.

module singles_merger #(
  parameter int NBLK      = 4,
  parameter int DATA_BITS = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                module_id,
  input  logic                      period_done,
  input  logic [NBLK*DATA_BITS-1:0] in_data,
  input  logic [NBLK-1:0]           in_valid,
  output logic [NBLK-1:0]           in_ready,
  input  logic [NBLK-1:0]           in_stall,
  output logic [DATA_BITS-1:0]      out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               tt_dropped
);

  localparam int PW = (NBLK > 1) ? $clog2(NBLK) : 1;

  logic [47:0]          tt_ctr;
  logic [47:0]          tt_cap;
  logic [47:0]          tt_next;
  logic                 tt_pend;
  logic                 tag_avail;
  logic                 tag_sel;
  logic                 load;
  logic [DATA_BITS-1:0] tag_word;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        grant;
  logic [PW-1:0]        grant_nxt;
  logic [PW-1:0]        cand;
  logic                 grant_vld;
  int                   idx;

  assign tt_next = tt_ctr + 48'd1;
  assign load    = ~out_valid | out_ready;

  // A period_done with no tag already pending is forwarded in the same
  // cycle, giving the one-cycle pulse-to-tag latency.
  assign tag_avail = (tt_pend | period_done) & ~|in_stall;
  assign tag_sel   = load & tag_avail;
  assign tag_word  = {5'b11111, 1'b0, module_id, 68'b0,
                      (tt_pend ? tt_cap : tt_next)};

  // First valid block at or after rr_ptr.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NBLK; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NBLK) idx = idx - NBLK;
      cand = PW'(idx);
      if (!grant_vld && in_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  assign grant_nxt = (grant == PW'(NBLK - 1)) ? '0 : grant + PW'(1);

  always_comb begin
    in_ready = '0;
    if (!rst && load && !tag_sel && grant_vld) in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (tag_sel) begin
        out_valid <= 1'b1;
        out_data  <= tag_word;
      end else if (grant_vld) begin
        out_valid <= 1'b1;
        out_data  <= in_data[DATA_BITS*grant +: DATA_BITS];
        rr_ptr    <= grant_nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // A new pulse coinciding with a tag load: if the tag being emitted was the
  // pending one, the new value stays pending; if the new value itself was
  // forwarded, nothing remains pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_ctr  <= '0;
      tt_cap  <= '0;
      tt_pend <= 1'b0;
    end else if (period_done) begin
      tt_ctr  <= tt_next;
      tt_cap  <= tt_next;
      tt_pend <= tt_pend | ~tag_sel;
    end else if (tag_sel) begin
      tt_pend <= 1'b0;
    end
  end

`ifdef SINGLES_MERGER_TT_STATS_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (period_done && tt_pend && !tag_sel && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign tt_dropped = drop_cnt;
`else
  assign tt_dropped = '0;
`endif

endmodule

// File: tb/tb_singles_merger.sv
module tb_singles_merger;
  localparam int NBLK = 4;
  localparam logic [5:0] MID = 6'h2A;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [5:0]           module_id;
  logic                 period_done;
  logic [NBLK*128-1:0]  in_data;
  logic [NBLK-1:0]      in_valid;
  logic [NBLK-1:0]      in_ready;
  logic [NBLK-1:0]      in_stall;
  logic [127:0]         out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          tt_dropped;

  singles_merger #(.NBLK(NBLK), .DATA_BITS(128)) dut (
    .clk(clk), .rst(rst), .module_id(module_id), .period_done(period_done),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_stall(in_stall), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .tt_dropped(tt_dropped)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the merged stream should look like.
  logic [47:0]  m_ctr;
  logic [47:0]  m_cap;
  bit           m_pend;
  int           m_ptr;
  bit           m_ov;
  logic [127:0] m_od;
  int           m_drop;

  function automatic logic [127:0] tag_of(input logic [47:0] v);
    return {5'h1F, 1'b0, MID, 68'b0, v};
  endfunction

  function automatic int drop_exp();
`ifdef SINGLES_MERGER_TT_STATS_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctr = '0; m_cap = '0; m_pend = 0; m_ptr = 0;
    m_ov = 0; m_od = '0; m_drop = 0;
  endtask

  // Called at posedge+1. Drives one cycle of inputs, checks in_ready, clocks,
  // then checks the registered outputs. g returns the expected grant (-1 none).
  task automatic cycle(input logic [NBLK-1:0] v, input logic [NBLK-1:0] st,
                       input bit pd, input bit ordy, output int g);
    bit load, tag;
    logic [47:0] tval;
    logic [NBLK-1:0] exp_rdy;
    in_valid = v; in_stall = st; period_done = pd; out_ready = ordy;
    for (int i = 0; i < NBLK; i++)
      in_data[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
    load = !m_ov || ordy;
    tag  = load && (m_pend || pd) && (st == '0);
    tval = m_pend ? m_cap : m_ctr + 48'd1;
    g = -1;
    for (int k = 0; k < NBLK; k++)
      if (g < 0 && v[(m_ptr + k) % NBLK]) g = (m_ptr + k) % NBLK;
    exp_rdy = '0;
    if (load && !tag && g >= 0) exp_rdy[g] = 1'b1;
    #1;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    if (load) begin
      if (tag) begin
        m_od = tag_of(tval); m_ov = 1;
      end else if (g >= 0) begin
        m_od = in_data[128*g +: 128]; m_ov = 1; m_ptr = (g + 1) % NBLK;
      end else begin
        m_ov = 0;
      end
    end
    if (pd) begin
      if (m_pend && !tag && m_drop < 65535) m_drop++;
      m_pend = m_pend || !tag;
      m_ctr  = m_ctr + 48'd1;
      m_cap  = m_ctr;
    end else if (tag) begin
      m_pend = 0;
    end
    @(posedge clk); #1;
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    if (m_ov) chk("out_data", out_data, m_od);
    chk("tt_dropped", 128'(tt_dropped), 128'(drop_exp()));
  endtask

  initial begin
    int g;
    logic [127:0] held;
    module_id = MID; rst = 1'b1; period_done = 0; in_valid = '0;
    in_stall = '0; out_ready = 0; in_data = '0;
    model_reset();
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_tt_dropped", 128'(tt_dropped), 128'(0));
    @(posedge clk); #1; rst = 1'b0;

    // First tag after reset carries 1, one cycle after the pulse.
    cycle('0, '0, 1, 1, g);
    chk("tag_first", out_data, {5'h1F, 1'b0, 6'h2A, 68'b0, 48'd1});
    cycle('0, '0, 0, 1, g);

    // Round robin with all blocks valid.
    for (int i = 0; i < 8; i++) begin
      cycle(4'hF, '0, 0, 1, g);
      chk("rr_order", 128'(g), 128'(i % 4));
    end

    // Backpressure: output held, no readies.
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      cycle(4'hF, '0, 0, 0, g);
      chk("hold_data", out_data, held);
    end
    for (int i = 0; i < 4; i++) cycle(4'hF, '0, 0, 1, g);
    cycle('0, '0, 0, 1, g);

    // Block 2 straddles the boundary: its event first, then the tag.
    m_ptr = m_ptr;
    cycle(4'b0100, 4'b0100, 1, 1, g);
    chk("stall_grant", 128'(g), 128'(2));
    chk("stall_no_tag", 128'(out_data[127:123] == 5'h1F), 128'(0));
    cycle('0, '0, 0, 1, g);
    chk("tag_after_stall", out_data, {5'h1F, 1'b0, 6'h2A, 68'b0, 48'd2});

    // Two pulses during a 10-cycle stall: one tag with the newer value.
    for (int i = 0; i < 10; i++) cycle('0, 4'b0001, (i == 0 || i == 3), 1, g);
    cycle('0, '0, 0, 1, g);
    chk("tag_overwrite", out_data, {5'h1F, 1'b0, 6'h2A, 68'b0, 48'd4});
`ifdef SINGLES_MERGER_TT_STATS_EN
    chk("drop_count", 128'(tt_dropped), 128'(1));
`else
    chk("drop_count", 128'(tt_dropped), 128'(0));
`endif

    // Reset with a held word and a pending tag.
    cycle(4'hF, '0, 0, 0, g);
    cycle('0, 4'b0010, 1, 0, g);
    #2; rst = 1'b1; #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", out_data, '0);
    chk("mid_rst_ready", 128'(in_ready), 128'(0));
    chk("mid_rst_drop", 128'(tt_dropped), 128'(0));
    @(posedge clk); #1; rst = 1'b0;
    model_reset();
    in_stall = '0;
    cycle('0, '0, 1, 1, g);
    chk("tag_after_rst", out_data, {5'h1F, 1'b0, 6'h2A, 68'b0, 48'd1});

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(4'($urandom),
            ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0,
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
